// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the IO bus arbiter: FSM state encoding and
// device id constants used by both the arbiter and IODevices.
package io_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IOB_IDLE  = 2'd0,
        IOB_ISSUE = 2'd1,
        IOB_WAIT  = 2'd2,
        IOB_RESP  = 2'd3
    } iob_state_e;

    localparam logic [7:0] PROM_ID    = 8'd2;
    localparam logic [7:0] CONSDEV_ID = 8'd3;
    localparam logic [7:0] IPC_ID     = 8'd7;

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
// Ports: req (request vector), ptr (priority start), grant (one-hot),
// grant_idx (encoded winner), grant_any (some request present).
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin : pick
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!grant_any && req[j]) begin
                grant_any = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one IODevices port between NUM_REQ requesters, one transaction at
// a time, round-robin. Ports: clk, reset (async, active-high);
// req_valid/req_ready/req_write/req_device_id/req_wdata (request side);
// rsp_valid/rsp_rdata (response side); io_device_id/io_value_in/
// io_is_write/io_value_out (device bus).
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ID_W-1:0]   req_device_id,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ID_W-1:0]           io_device_id,
    output logic [DATA_W-1:0]         io_value_in,
    output logic                      io_is_write,
    input  logic [DATA_W-1:0]         io_value_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (RD_LATENCY >= 1) ? $clog2(RD_LATENCY + 1) : 1;

    if (RD_LATENCY < 1) begin : g_bad_latency
        $error("io_bus_arbiter: RD_LATENCY must be >= 1");
    end

    iob_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                io_is_write_q, io_is_write_d;
    logic [ID_W-1:0]     io_device_id_q, io_device_id_d;
    logic [DATA_W-1:0]   io_value_in_q, io_value_in_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        io_is_write_d  = 1'b0;
        io_device_id_d = io_device_id_q;
        io_value_in_d  = io_value_in_q;
        rsp_rdata_d    = rsp_rdata_q;
        unique case (state_q)
            IOB_IDLE: begin
                if (grant_any) begin
                    owner_d = grant_idx;
                    if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx + IDX_W'(1);
                    end
                    // Bus is loaded on the accept edge so it is valid
                    // for the whole ISSUE cycle.
                    io_is_write_d  = req_write[grant_idx];
                    io_device_id_d = req_device_id[grant_idx*ID_W +: ID_W];
                    io_value_in_d  = req_wdata[grant_idx*DATA_W +: DATA_W];
                    state_d        = IOB_ISSUE;
                end
            end
            IOB_ISSUE: begin
                if (io_is_write_q) begin
                    rsp_rdata_d = '0;
                    state_d     = IOB_RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                    state_d = IOB_WAIT;
                end
            end
            IOB_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = io_value_out;
                    state_d     = IOB_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IOB_RESP: begin
                state_d = IOB_IDLE;
            end
            default: begin
                state_d = IOB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IOB_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            cnt_q          <= '0;
            io_is_write_q  <= 1'b0;
            io_device_id_q <= '0;
            io_value_in_q  <= '0;
            rsp_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            io_is_write_q  <= io_is_write_d;
            io_device_id_q <= io_device_id_d;
            io_value_in_q  <= io_value_in_d;
            rsp_rdata_q    <= rsp_rdata_d;
        end
    end

    // Ready is masked by reset because IDLE is also the reset state.
    always_comb begin
        req_ready = '0;
        if (state_q == IOB_IDLE && !reset) begin
            req_ready = grant;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == IOB_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign rsp_rdata    = rsp_rdata_q;
    assign io_device_id = io_device_id_q;
    assign io_value_in  = io_value_in_q;
    assign io_is_write  = io_is_write_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: randomized and directed requests, a
// transaction-level reference model and a scoreboard of responses.
module tb_io_bus_arbiter;
    import io_bus_arbiter_pkg::*;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int IW  = 8;
    localparam int LAT = 3;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write;
    logic [N*IW-1:0] req_device_id;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [IW-1:0]   io_device_id;
    logic [DW-1:0]   io_value_in;
    logic            io_is_write;
    logic [DW-1:0]   io_value_out;

    io_bus_arbiter #(
        .NUM_REQ    (N),
        .DATA_W     (DW),
        .ID_W       (IW),
        .RD_LATENCY (LAT)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_device_id (req_device_id),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .io_device_id  (io_device_id),
        .io_value_in   (io_value_in),
        .io_is_write   (io_is_write),
        .io_value_out  (io_value_out)
    );

    typedef struct {
        int          cyc;
        int          owner;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   tot = 0;
    int   bad = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Device behaviour: value depends on cycle number and bus contents.
    function automatic logic [31:0] devval(input int c, input logic [7:0] id,
                                           input logic [31:0] v);
        logic [31:0] cc;
        cc = c;
        return {cc[15:0] ^ 16'hA5C3, id ^ 8'h3C, v[7:0]};
    endfunction

    initial begin
        io_value_out = '0;
        forever begin
            @(posedge clk);
            #1;
            io_value_out = devval(cyc, io_device_id, io_value_in);
        end
    end

    // Reference model: grant rule, bus contents and response timing.
    int          ptr = 0;
    int          free_cyc = 0;
    int          iss_cyc = -1;
    logic        iss_wr = 1'b0;
    logic [7:0]  bus_id = '0;
    logic [31:0] bus_val = '0;

    always @(negedge clk) begin : model
        int          g;
        int          j;
        logic [N-1:0] exp_rdy;
        exp_t        e;
        logic        wr;
        logic [7:0]  id;
        logic [31:0] dat;
        if (reset) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_is_write", io_is_write, 0);
            chk("rst_dev_id", io_device_id, 0);
            chk("rst_value_in", io_value_in, 0);
            chk("rst_rdata", rsp_rdata, 0);
            ptr      = 0;
            free_cyc = 0;
            iss_cyc  = -1;
            bus_id   = '0;
            bus_val  = '0;
            exp_q.delete();
        end else begin
            chk("is_write", io_is_write, (cyc == iss_cyc) ? iss_wr : 1'b0);
            chk("dev_id", io_device_id, bus_id);
            chk("value_in", io_value_in, bus_val);
            g = -1;
            if (cyc >= free_cyc) begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr + k) % N;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            if (g >= 0) begin
                wr      = req_write[g];
                id      = req_device_id[g*IW +: IW];
                dat     = req_wdata[g*DW +: DW];
                e.owner = g;
                e.cyc   = wr ? cyc + 2 : cyc + 2 + LAT;
                e.rdata = wr ? 32'd0 : devval(cyc + 1 + LAT, id, dat);
                exp_q.push_back(e);
                free_cyc = e.cyc + 1;
                ptr      = (g + 1) % N;
                iss_cyc  = cyc + 1;
                iss_wr   = wr;
                bus_id   = id;
                bus_val  = dat;
            end
        end
    end

    // Response monitor.
    logic [31:0] last_rdata = '0;

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [N-1:0] oh;
        if (reset) begin
            last_rdata = '0;
        end else if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 0);
            end else begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e.owner] = 1'b1;
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_owner", rsp_valid, oh);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                last_rdata = e.rdata;
            end
        end else begin
            chk("rdata_hold", rsp_rdata, last_rdata);
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("rsp_timeout", 0, e.cyc);
            end
        end
    end

    // Stimulus.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [7:0] id,
                           input logic [31:0] d);
        req_write[i]             = wr;
        req_device_id[i*IW +: IW] = id;
        req_wdata[i*DW +: DW]     = d;
    endtask

    function automatic logic [7:0] pick_id();
        case ($urandom_range(0, 3))
            0:       return PROM_ID;
            1:       return CONSDEV_ID;
            2:       return IPC_ID;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'($urandom_range(0, 1)), pick_id(), $urandom);
        end
    endtask

    task automatic wait_accept(input int i);
        bit done;
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (req_ready[i] && req_valid[i]) done = 1;
        end
        if (!done) chk("accept_timeout", i, 99);
        step();
        req_valid[i] = 1'b0;
    endtask

    task automatic issue(input int i, input logic wr, input logic [7:0] id,
                         input logic [31:0] d);
        set_req(i, wr, id, d);
        req_valid[i] = 1'b1;
        wait_accept(i);
    endtask

    initial begin
        reset         = 1'b0;
        req_valid     = '0;
        req_write     = '0;
        req_device_id = '0;
        req_wdata     = '0;
        #1;
        reset     = 1'b1;
        req_valid = 2'b11;
        rand_fields();
        repeat (4) step();
        reset = 1'b0;

        // Both requesters continuously valid.
        repeat (40) begin
            rand_fields();
            step();
        end
        req_valid = '0;
        repeat (8) step();

        issue(0, 1'b1, CONSDEV_ID, 32'h0000_00AB);
        repeat (4) step();
        issue(1, 1'b0, PROM_ID, 32'h0000_0004);
        repeat (8) step();

        // Reset in the middle of a read's WAIT phase, req1 pending.
        set_req(1, 1'b1, CONSDEV_ID, 32'h0000_0055);
        req_valid[1] = 1'b1;
        issue(0, 1'b0, IPC_ID, 32'h0000_0010);
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        wait_accept(1);
        repeat (8) step();

        // Read from IPC with a device value that changes every cycle.
        issue(1, 1'b0, IPC_ID, 32'h1234_5678);
        repeat (8) step();

        // Random traffic, including valids that drop before being served.
        repeat (500) begin
            req_valid = N'($urandom_range(0, 3));
            rand_fields();
            step();
        end
        req_valid = '0;
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) step();
        if (exp_q.size() > 0) chk("drain", exp_q.size(), 0);
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
